// File: rtl/mul_fix_point_pipe.sv
// Pipelined signed fixed-point multiplier Q(WIDTH-FRAC).FRAC with optional rounding/saturation,
// overflow flags and valid/ready flow control driven by a single global stage enable.
module mul_fix_point_pipe #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned ROUND    = 1,
  parameter int unsigned SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mul_out,
  output logic             ovf,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int unsigned PW = 2 * WIDTH + 1;

  logic signed [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic signed [PW-1:0]      prod_ext, prod_rnd, r_full;
  logic        [PW-1:0]      rnd_const;
  logic        [PW-WIDTH:0]  hi_bits;
  logic                      res_ovf;
  logic        [WIDTH-1:0]   res;

  logic                      en;
  logic        [STAGES-1:0]  valid_q;
  logic        [STAGES-1:0]  ovf_q;
  logic        [WIDTH-1:0]   res_q [STAGES];
  logic                      sticky_q;

  // Whole result is formed before the first register; later stages only retime it.
  always_comb begin
    a_ext     = {{WIDTH{a[WIDTH-1]}}, a};
    b_ext     = {{WIDTH{b[WIDTH-1]}}, b};
    prod      = a_ext * b_ext;
    prod_ext  = {prod[2*WIDTH-1], prod};
    rnd_const = (ROUND != 0) ? (PW'(1) << (FRAC - 1)) : '0;
    prod_rnd  = prod_ext + $signed(rnd_const);
    r_full    = prod_rnd >>> FRAC;
    // In range iff every bit from the result sign upwards agrees.
    hi_bits   = r_full[PW-1:WIDTH-1];
    res_ovf   = !((&hi_bits) || !(|hi_bits));
    if (res_ovf && (SATURATE != 0)) begin
      res = r_full[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res = r_full[WIDTH-1:0];
    end
  end

  assign en       = !valid_q[STAGES-1] || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
      end
    end else if (en) begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        res_q[0] <= res;
        ovf_q[0] <= res_ovf;
      end
      // Data only moves with a valid token so outputs hold their last value across bubbles.
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          res_q[i] <= res_q[i-1];
          ovf_q[i] <= ovf_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (out_valid && out_ready && ovf) begin
      sticky_q <= 1'b1;
    end else if (clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign out_valid  = valid_q[STAGES-1];
  assign mul_out    = res_q[STAGES-1];
  assign ovf        = ovf_q[STAGES-1];
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_mul_fix_point_pipe.sv
// Directed bench for mul_fix_point_pipe: default, truncating and wrapping instances share stimulus.
module tb_mul_fix_point_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        clr_sticky;
  logic [15:0] a, b;

  logic        in_ready,   out_valid,   ovf,   ovf_sticky;
  logic [15:0] mul_out;
  logic        in_ready_t, out_valid_t, ovf_t, ovf_sticky_t;
  logic [15:0] mul_out_t;
  logic        in_ready_w, out_valid_w, ovf_w, ovf_sticky_w;
  logic [15:0] mul_out_w;

  int checks = 0;
  int errors = 0;

  mul_fix_point_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .mul_out(mul_out), .ovf(ovf),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  mul_fix_point_pipe #(.ROUND(0)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t), .a(a), .b(b),
    .out_valid(out_valid_t), .out_ready(out_ready), .mul_out(mul_out_t), .ovf(ovf_t),
    .ovf_sticky(ovf_sticky_t), .clr_sticky(clr_sticky)
  );

  mul_fix_point_pipe #(.SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w), .a(a), .b(b),
    .out_valid(out_valid_w), .out_ready(out_ready), .mul_out(mul_out_w), .ovf(ovf_w),
    .ovf_sticky(ovf_sticky_w), .clr_sticky(clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready high; return after the cycle its result first becomes visible.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b);
    @(negedge clk);
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("latency_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq("latency_valid", {29'd0, out_valid, out_valid_t, out_valid_w}, 32'd7);
  endtask

  // Directed vectors: a, b, expected (default), expected ovf
  logic [15:0] va  [8] = '{16'h0100, 16'h0300, 16'h0300, 16'h0030,
                           16'h0001, 16'hFFFF, 16'h7F00, 16'h8000};
  logic [15:0] vb  [8] = '{16'h0200, 16'h0300, 16'hFE00, 16'h0030,
                           16'h0080, 16'h0080, 16'h0200, 16'h8000};
  logic [15:0] ve  [8] = '{16'h0200, 16'h0900, 16'hFA00, 16'h0009,
                           16'h0001, 16'h0000, 16'h7FFF, 16'h7FFF};
  logic        vo  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    logic [15:0] exp_q[$];
    logic [15:0] held;
    logic        stalled;
    int          sent, got, cyc;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;
    a          = '0;
    b          = '0;
    #12;
    check_eq("reset_state", {13'd0, out_valid, ovf, ovf_sticky, mul_out}, 32'd0);
    check_eq("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i]);
      check_eq($sformatf("vec%0d_out", i), {16'd0, mul_out}, {16'd0, ve[i]});
      check_eq($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vo[i]});
    end

    run_op(16'h0001, 16'h0080);
    check_eq("trunc_half_pos", {16'd0, mul_out_t}, 32'h0000);
    run_op(16'hFFFF, 16'h0080);
    check_eq("trunc_half_neg", {16'd0, mul_out_t}, 32'h0000_FFFF);
    run_op(16'h7F00, 16'h0200);
    check_eq("wrap_out", {16'd0, mul_out_w}, 32'h0000_FE00);
    check_eq("wrap_ovf", {31'd0, ovf_w}, 32'd1);
    run_op(16'h8000, 16'h0200);
    check_eq("sat_neg_out", {16'd0, mul_out}, 32'h0000_8000);
    check_eq("sat_neg_ovf", {31'd0, ovf}, 32'd1);
    run_op(16'h8000, 16'h8000);
    check_eq("wrap_big_out", {16'd0, mul_out_w}, 32'h0000_0000);

    // Sticky: already set by overflowing transfers above; clear, then set again.
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check_eq("sticky_lone_clr0", {31'd0, ovf_sticky}, 32'd0);
    run_op(16'h7F00, 16'h0200);
    check_eq("sticky_before_xfer", {31'd0, ovf_sticky}, 32'd0);
    @(negedge clk);
    check_eq("sticky_set", {31'd0, ovf_sticky}, 32'd1);
    run_op(16'h7F00, 16'h0200);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check_eq("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check_eq("sticky_lone_clr", {31'd0, ovf_sticky}, 32'd0);

    // Backpressure stream with random out_ready.
    sent    = 0;
    got     = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (got < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 8);
      a         = va[sent % 8];
      b         = vb[sent % 8];
      #1;
      check_eq("bp_in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (stalled) begin
        check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check_eq("bp_hold_data", {16'd0, mul_out}, {16'd0, held});
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ve[sent]);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("bp_unexpected", {31'd0, out_valid}, 32'd0);
        end else begin
          check_eq($sformatf("bp_res%0d", got), {16'd0, mul_out}, {16'd0, exp_q.pop_front()});
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = mul_out;
    end
    check_eq("bp_all_received", got, 32'd8);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset mid-stream with two results in flight and sticky set.
    run_op(16'h7F00, 16'h0200);
    @(negedge clk);
    check_eq("pre_reset_sticky", {31'd0, ovf_sticky}, 32'd1);
    in_valid = 1'b1;
    a        = 16'h0300;
    b        = 16'h0300;
    @(negedge clk);
    a = 16'h0100;
    b = 16'h0200;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("mid_reset", {14'd0, out_valid, ovf_sticky, mul_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0300, 16'hFE00);
    check_eq("post_reset_out", {16'd0, mul_out}, 32'h0000_FA00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
